// File: rtl/text_pixel_colour_pipe.sv
// Text-mode pixel colour stage: attribute + glyph bit -> palette colour, with attribute/cursor
// blink driven by a frame-counted timer and a 2-stage valid pipeline.
module text_pixel_colour_pipe #(
  parameter int COLOR_W      = 8,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pal_we_i,
  input  logic [3:0]           pal_addr_i,
  input  logic [3*COLOR_W-1:0] pal_wdata_i,
  output logic [3*COLOR_W-1:0] pal_rdata_o,
  input  logic                 blink_en_i,
  input  logic                 frame_start_i,
  input  logic                 valid_i,
  input  logic [7:0]           attribute_i,
  input  logic                 glyph_bit_i,
  input  logic                 cursor_i,
  output logic                 valid_o,
  output logic [3*COLOR_W-1:0] rgb_o,
  output logic                 blink_phase_o
);

  localparam int RGB_W = 3 * COLOR_W;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // Standard VGA colour for a palette slot, each channel cut to its top COLOR_W bits.
  function automatic logic [RGB_W-1:0] vga_default(input logic [3:0] idx);
    logic [23:0] c;
    case (idx)
      4'h0:    c = 24'h000000;
      4'h1:    c = 24'h0000AA;
      4'h2:    c = 24'h00AA00;
      4'h3:    c = 24'h00AAAA;
      4'h4:    c = 24'hAA0000;
      4'h5:    c = 24'hAA00AA;
      4'h6:    c = 24'hAA5500;
      4'h7:    c = 24'hAAAAAA;
      4'h8:    c = 24'h555555;
      4'h9:    c = 24'h5555FF;
      4'hA:    c = 24'h55FF55;
      4'hB:    c = 24'h55FFFF;
      4'hC:    c = 24'hFF5555;
      4'hD:    c = 24'hFF55FF;
      4'hE:    c = 24'hFFFF55;
      4'hF:    c = 24'hFFFFFF;
      default: c = 24'h000000;
    endcase
    return {c[23 -: COLOR_W], c[15 -: COLOR_W], c[7 -: COLOR_W]};
  endfunction

  logic [RGB_W-1:0] r_pal [16];
  logic [RGB_W-1:0] r_pal_rdata;
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink_phase;
  logic             r_s1_valid;
  logic             r_s1_sel_fg;
  logic [3:0]       r_s1_fg_idx;
  logic [3:0]       r_s1_bg_idx;
  logic             r_s2_valid;
  logic [RGB_W-1:0] r_s2_rgb;

  logic       w_sel_fg;
  logic [3:0] w_bg_idx;
  logic [3:0] w_s2_idx;

  // Palette storage: defaults on reset, single write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) begin
        r_pal[i] <= vga_default(4'(i));
      end
    end else if (pal_we_i) begin
      r_pal[pal_addr_i] <= pal_wdata_i;
    end
  end

  // Readback port; samples the array before any same-edge write lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pal_rdata <= {RGB_W{1'b0}};
    end else begin
      r_pal_rdata <= r_pal[pal_addr_i];
    end
  end

  // Blink timer: frame pulses counted modulo BLINK_FRAMES, phase toggles on wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_blink_cnt   <= {CNT_W{1'b0}};
      r_blink_phase <= 1'b0;
    end else if (frame_start_i) begin
      if (r_blink_cnt == CNT_LAST) begin
        r_blink_cnt   <= {CNT_W{1'b0}};
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + CNT_W'(1);
      end
    end
  end

  // Stage-1 decode: background index mode and foreground select against the pre-edge phase.
  always_comb begin
    w_bg_idx = attribute_i[7:4];
    if (blink_en_i) begin
      w_bg_idx = {1'b0, attribute_i[6:4]};
    end else begin
      w_bg_idx = attribute_i[7:4];
    end
    w_sel_fg = (glyph_bit_i & ~(blink_en_i & attribute_i[7] & r_blink_phase))
             | (cursor_i & ~r_blink_phase);
  end

  assign w_s2_idx = r_s1_sel_fg ? r_s1_fg_idx : r_s1_bg_idx;

  // Two-stage pipeline; bubbles carry through with a black colour.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid  <= 1'b0;
      r_s1_sel_fg <= 1'b0;
      r_s1_fg_idx <= 4'h0;
      r_s1_bg_idx <= 4'h0;
      r_s2_valid  <= 1'b0;
      r_s2_rgb    <= {RGB_W{1'b0}};
    end else begin
      r_s1_valid  <= valid_i;
      r_s1_sel_fg <= w_sel_fg;
      r_s1_fg_idx <= attribute_i[3:0];
      r_s1_bg_idx <= w_bg_idx;
      r_s2_valid  <= r_s1_valid;
      r_s2_rgb    <= r_s1_valid ? r_pal[w_s2_idx] : {RGB_W{1'b0}};
    end
  end

  assign pal_rdata_o   = r_pal_rdata;
  assign valid_o       = r_s2_valid;
  assign rgb_o         = r_s2_rgb;
  assign blink_phase_o = r_blink_phase;

endmodule

// File: tb/tb_text_pixel_colour_pipe.sv
// Self-checking bench for text_pixel_colour_pipe: directed scenarios plus randomized traffic
// compared every cycle against a cycle-level reference model of the colour rules.
module tb_text_pixel_colour_pipe;

  localparam int CW = 8;
  localparam int BF = 16;
  localparam logic [23:0] VGA [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA, 24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF, 24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};

  logic        clk_i = 1'b0;
  logic        rst_i, pal_we_i, blink_en_i, frame_start_i, valid_i, glyph_bit_i, cursor_i;
  logic [3:0]  pal_addr_i;
  logic [23:0] pal_wdata_i, pal_rdata_o, rgb_o;
  logic [7:0]  attribute_i;
  logic        valid_o, blink_phase_o;

  int n_tests = 0;
  int n_fail  = 0;

  text_pixel_colour_pipe #(.COLOR_W(CW), .BLINK_FRAMES(BF)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pal_we_i(pal_we_i), .pal_addr_i(pal_addr_i),
    .pal_wdata_i(pal_wdata_i), .pal_rdata_o(pal_rdata_o), .blink_en_i(blink_en_i),
    .frame_start_i(frame_start_i), .valid_i(valid_i), .attribute_i(attribute_i),
    .glyph_bit_i(glyph_bit_i), .cursor_i(cursor_i), .valid_o(valid_o), .rgb_o(rgb_o),
    .blink_phase_o(blink_phase_o));

  always #5 clk_i = ~clk_i;

  // Reference model: palette contents, frame count, phase, and the pixel waiting for its lookup.
  logic [23:0] m_pal [16];
  int          m_cnt;
  logic        m_phase;
  logic        m_p_valid;
  logic [3:0]  m_p_idx;
  logic        m_exp_valid;
  logic [23:0] m_exp_rgb, m_exp_rdata;

  always @(posedge clk_i) begin
    automatic logic       sel;
    automatic logic [3:0] bg;
    if (rst_i) begin
      for (int i = 0; i < 16; i++) m_pal[i] <= VGA[i];
      m_cnt <= 0; m_phase <= 1'b0; m_p_valid <= 1'b0; m_p_idx <= 4'h0;
      m_exp_valid <= 1'b0; m_exp_rgb <= 24'h0; m_exp_rdata <= 24'h0;
    end else begin
      m_exp_valid <= m_p_valid;
      m_exp_rgb   <= m_p_valid ? m_pal[m_p_idx] : 24'h0;
      m_exp_rdata <= m_pal[pal_addr_i];
      sel = (glyph_bit_i && !(blink_en_i && attribute_i[7] && m_phase)) || (cursor_i && !m_phase);
      bg  = blink_en_i ? {1'b0, attribute_i[6:4]} : attribute_i[7:4];
      m_p_valid <= valid_i;
      m_p_idx   <= sel ? attribute_i[3:0] : bg;
      if (pal_we_i) m_pal[pal_addr_i] <= pal_wdata_i;
      if (frame_start_i) begin
        if (m_cnt == BF - 1) begin
          m_cnt   <= 0;
          m_phase <= ~m_phase;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    pal_we_i = 1'b0; pal_addr_i = 4'h0; pal_wdata_i = 24'h0; blink_en_i = 1'b0;
    frame_start_i = 1'b0; valid_i = 1'b0; attribute_i = 8'h00; glyph_bit_i = 1'b0; cursor_i = 1'b0;
  endtask

  task automatic pulse_frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_start_i = 1'b1; tick();
      frame_start_i = 1'b0; tick();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1; valid_i = 1'b1; glyph_bit_i = 1'b1; attribute_i = 8'hFF;
    tick(); tick();
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", valid_o); end
    n_tests++; if (rgb_o !== 24'h0) begin n_fail++; $display("FAIL reset_rgb got %h want 000000", rgb_o); end
    n_tests++; if (blink_phase_o !== 1'b0) begin n_fail++; $display("FAIL reset_phase got %0b want 0", blink_phase_o); end
    n_tests++; if (pal_rdata_o !== 24'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 000000", pal_rdata_o); end
    idle_inputs();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_attr_basic();
    valid_i = 1'b1; attribute_i = 8'h1E; glyph_bit_i = 1'b1;
    tick();
    glyph_bit_i = 1'b0;
    tick();
    n_tests++; if (valid_o !== 1'b1 || rgb_o !== 24'hFFFF55) begin n_fail++; $display("FAIL attr_fg got v=%0b %h want 1 FFFF55", valid_o, rgb_o); end
    valid_i = 1'b0;
    tick();
    n_tests++; if (valid_o !== 1'b1 || rgb_o !== 24'h0000AA) begin n_fail++; $display("FAIL attr_bg got v=%0b %h want 1 0000AA", valid_o, rgb_o); end
    idle_inputs(); tick();
  endtask

  task automatic test_blink();
    blink_en_i = 1'b1; valid_i = 1'b1; attribute_i = 8'h9F; glyph_bit_i = 1'b1;
    tick(); valid_i = 1'b0; tick();
    n_tests++; if (rgb_o !== 24'hFFFFFF) begin n_fail++; $display("FAIL blink_phase0 got %h want FFFFFF", rgb_o); end
    pulse_frames(BF - 1);
    n_tests++; if (blink_phase_o !== 1'b0) begin n_fail++; $display("FAIL blink_before_wrap got %0b want 0", blink_phase_o); end
    pulse_frames(1);
    n_tests++; if (blink_phase_o !== 1'b1) begin n_fail++; $display("FAIL blink_wrap got %0b want 1", blink_phase_o); end
    valid_i = 1'b1;
    tick(); valid_i = 1'b0; tick();
    n_tests++; if (rgb_o !== 24'h0000AA) begin n_fail++; $display("FAIL blink_phase1 got %h want 0000AA", rgb_o); end
    blink_en_i = 1'b0; glyph_bit_i = 1'b0; valid_i = 1'b1;
    tick(); valid_i = 1'b0; tick();
    n_tests++; if (rgb_o !== 24'h5555FF) begin n_fail++; $display("FAIL bright_bg got %h want 5555FF", rgb_o); end
    idle_inputs(); tick();
  endtask

  task automatic test_palette_write();
    valid_i = 1'b1; attribute_i = 8'h04; glyph_bit_i = 1'b1; pal_addr_i = 4'h4;
    tick();
    pal_we_i = 1'b1; pal_wdata_i = 24'h123456;
    tick();
    n_tests++; if (rgb_o !== 24'hAA0000) begin n_fail++; $display("FAIL pal_same_cycle got %h want AA0000", rgb_o); end
    n_tests++; if (pal_rdata_o !== 24'hAA0000) begin n_fail++; $display("FAIL pal_rd_old got %h want AA0000", pal_rdata_o); end
    pal_we_i = 1'b0; valid_i = 1'b0;
    tick();
    n_tests++; if (rgb_o !== 24'h123456) begin n_fail++; $display("FAIL pal_next_cycle got %h want 123456", rgb_o); end
    n_tests++; if (pal_rdata_o !== 24'h123456) begin n_fail++; $display("FAIL pal_rd_new got %h want 123456", pal_rdata_o); end
    idle_inputs(); tick();
  endtask

  task automatic test_cursor();
    cursor_i = 1'b1; attribute_i = 8'h07; valid_i = 1'b1;
    tick(); valid_i = 1'b0; tick();
    n_tests++; if (rgb_o !== 24'h000000 || valid_o !== 1'b1) begin n_fail++; $display("FAIL cursor_phase1 got v=%0b %h want 1 000000", valid_o, rgb_o); end
    pulse_frames(BF);
    n_tests++; if (blink_phase_o !== 1'b0) begin n_fail++; $display("FAIL cursor_phase_back got %0b want 0", blink_phase_o); end
    valid_i = 1'b1;
    tick(); valid_i = 1'b0; tick();
    n_tests++; if (rgb_o !== 24'hAAAAAA) begin n_fail++; $display("FAIL cursor_phase0 got %h want AAAAAA", rgb_o); end
    idle_inputs(); tick();
  endtask

  task automatic test_bubbles();
    attribute_i = 8'h0F; glyph_bit_i = 1'b1; valid_i = 1'b1;
    tick(); valid_i = 1'b0;
    tick();
    n_tests++; if (valid_o !== 1'b1 || rgb_o !== 24'hFFFFFF) begin n_fail++; $display("FAIL bubble_first got v=%0b %h want 1 FFFFFF", valid_o, rgb_o); end
    valid_i = 1'b1;
    tick();
    n_tests++; if (valid_o !== 1'b0 || rgb_o !== 24'h0) begin n_fail++; $display("FAIL bubble_gap got v=%0b %h want 0 000000", valid_o, rgb_o); end
    valid_i = 1'b0;
    tick();
    n_tests++; if (valid_o !== 1'b1 || rgb_o !== 24'hFFFFFF) begin n_fail++; $display("FAIL bubble_third got v=%0b %h want 1 FFFFFF", valid_o, rgb_o); end
    idle_inputs(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      valid_i       = ($urandom_range(0, 3) != 0);
      attribute_i   = 8'($urandom);
      glyph_bit_i   = 1'($urandom);
      cursor_i      = ($urandom_range(0, 5) == 0);
      blink_en_i    = ($urandom_range(0, 3) != 0);
      frame_start_i = ($urandom_range(0, 2) == 0);
      pal_we_i      = ($urandom_range(0, 9) == 0);
      pal_addr_i    = 4'($urandom);
      pal_wdata_i   = 24'($urandom);
      tick();
      n_tests++; if (valid_o !== m_exp_valid) begin n_fail++; $display("FAIL rand_valid c=%0d got %0b want %0b", c, valid_o, m_exp_valid); end
      n_tests++; if (rgb_o !== m_exp_rgb) begin n_fail++; $display("FAIL rand_rgb c=%0d got %h want %h", c, rgb_o, m_exp_rgb); end
      n_tests++; if (blink_phase_o !== m_phase) begin n_fail++; $display("FAIL rand_phase c=%0d got %0b want %0b", c, blink_phase_o, m_phase); end
      n_tests++; if (pal_rdata_o !== m_exp_rdata) begin n_fail++; $display("FAIL rand_rdata c=%0d got %h want %h", c, pal_rdata_o, m_exp_rdata); end
    end
    idle_inputs(); tick();
  endtask

  task automatic test_reset_midflight();
    pal_we_i = 1'b1; pal_addr_i = 4'h4; pal_wdata_i = 24'h123456;
    tick(); pal_we_i = 1'b0;
    for (int k = 0; k < 40 && m_phase !== 1'b1; k++) pulse_frames(1);
    n_tests++; if (blink_phase_o !== 1'b1) begin n_fail++; $display("FAIL mid_phase_setup got %0b want 1", blink_phase_o); end
    valid_i = 1'b1; attribute_i = 8'h0F; glyph_bit_i = 1'b1;
    tick();
    rst_i = 1'b1;
    tick();
    n_tests++; if (valid_o !== 1'b0 || rgb_o !== 24'h0) begin n_fail++; $display("FAIL mid_drop got v=%0b %h want 0 000000", valid_o, rgb_o); end
    n_tests++; if (blink_phase_o !== 1'b0) begin n_fail++; $display("FAIL mid_phase got %0b want 0", blink_phase_o); end
    rst_i = 1'b0; valid_i = 1'b1; attribute_i = 8'h04; pal_addr_i = 4'h4;
    tick();
    n_tests++; if (pal_rdata_o !== 24'hAA0000) begin n_fail++; $display("FAIL mid_pal_rd got %h want AA0000", pal_rdata_o); end
    valid_i = 1'b0;
    tick();
    n_tests++; if (valid_o !== 1'b1 || rgb_o !== 24'hAA0000) begin n_fail++; $display("FAIL mid_pal_px got v=%0b %h want 1 AA0000", valid_o, rgb_o); end
    idle_inputs(); tick();
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    test_reset();
    test_attr_basic();
    test_blink();
    test_palette_write();
    test_cursor();
    test_bubbles();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
